// File: rtl/p1_pkg.sv
// Shared types and constants for the p1 truth-table sweep logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package p1_pkg;

    localparam int P1_NUM_VECTORS = 16;
    localparam int P1_IDX_W       = 4;

    // Index of the final vector; reaching it is the only way out of a sweep.
    localparam logic [P1_IDX_W-1:0] P1_LAST_IDX = P1_IDX_W'(P1_NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FIN   = 2'd2
    } p1_state_t;

endpackage

// File: rtl/p1_hold_timer.sv
// Hold counter: counts cycles while en is high, flags the last cycle of each hold window.
// Latency: last is combinational from the count; count restarts the cycle after last.
// Backpressure: none; dropping en clears the count so the next window starts fresh.
module p1_hold_timer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic last
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at the end of each window, hold at zero while disabled.
    always_comb begin
        last  = en && (cnt_q == LAST_VAL);
        cnt_d = cnt_q;
        if (!en || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/p1_sweep_ctrl.sv
// Sweeps {a,b,c,d} through all 16 vectors, holding each HOLD_CYCLES and sampling q into table_out.
// Latency: done pulses 1+16*HOLD_CYCLES cycles after start is sampled; table_out/mismatch final with done.
// Backpressure: none; start is only honoured in IDLE. Build option P1_SWEEP_CHECK_EN enables mismatch.
module p1_sweep_ctrl #(
    parameter int          HOLD_CYCLES = 10,
    parameter logic [15:0] EXPECTED    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        q,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        mismatch
);

    import p1_pkg::*;

    p1_state_t                state_q, state_d;
    logic [P1_IDX_W-1:0]      idx_q, idx_d;
    logic [P1_NUM_VECTORS-1:0] table_q, table_d;
    logic                     hold_last;
    logic                     start_acc;
    logic                     sweep_end;

    p1_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == DRIVE),
        .last (hold_last)
    );

    assign start_acc = (state_q == IDLE) && start;
    assign sweep_end = (state_q == DRIVE) && hold_last && (idx_q == P1_LAST_IDX);

    // State, vector index and captured table registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            table_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
        end
    end

    // Next-state: one pass over all vectors, one FIN cycle, back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = DRIVE;
            DRIVE:   if (sweep_end) state_d = FIN;
            FIN:                    state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Index advance and q capture on the last cycle of each hold window.
    always_comb begin
        idx_d   = idx_q;
        table_d = table_q;
        if (start_acc) begin
            idx_d   = '0;
            table_d = '0;
        end else if ((state_q == DRIVE) && hold_last) begin
            table_d[idx_q] = q;
            if (idx_q != P1_LAST_IDX) begin
                idx_d = idx_q + 1'b1;
            end
        end else if (state_q == FIN) begin
            idx_d = '0;
        end
    end

    // Outputs decoded from state; the vector is only driven while sweeping.
    always_comb begin
        busy         = (state_q == DRIVE);
        done         = (state_q == FIN);
        {a, b, c, d} = (state_q == DRIVE) ? idx_q : '0;
    end

    assign table_out = table_q;

`ifdef P1_SWEEP_CHECK_EN
    logic mismatch_q, mismatch_d;

    // Compare against the table as it will look in FIN, so the flag lands with done.
    always_comb begin
        mismatch_d = mismatch_q;
        if (start_acc) begin
            mismatch_d = 1'b0;
        end else if (sweep_end) begin
            mismatch_d = (table_d != EXPECTED);
        end
    end

    // Mismatch flag register, held through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    localparam logic [15:0] unused_expected = EXPECTED;
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_p1_sweep_ctrl.sv
// Bench for p1_sweep_ctrl: three instances (hold 10, 3, 1) with modelled p1 cells.
// Latency: n/a.
// Backpressure: n/a.
module tb_p1_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef P1_SWEEP_CHECK_EN
    localparam logic EXP_MM_CORRUPT = 1'b1;
`else
    localparam logic EXP_MM_CORRUPT = 1'b0;
`endif

    logic rst10, rst3, rst1;
    logic start10, start3, start1;
    logic a10, b10, c10, d10, busy10, done10, mm10, q10;
    logic a3, b3, c3, d3, busy3, done3, mm3, q3;
    logic a1, b1, c1, d1, busy1, done1, mm1, q1;
    logic [15:0] tbl10, tbl3, tbl1;
    logic corrupt10;

    // p1 models: a^d, optionally forced low during vector 3; constant 1 for the min-hold unit.
    assign q10 = (corrupt10 && ({a10, b10, c10, d10} == 4'd3)) ? 1'b0 : (a10 ^ d10);
    assign q3  = a3 ^ d3;
    assign q1  = 1'b1;

    logic [15:0] exp_tbl10[$];
    logic        exp_mm10[$];
    logic [3:0]  exp_vec3[$];
    logic [15:0] exp_tbl3[$];
    logic [15:0] exp_tbl1[$];

    p1_sweep_ctrl #(.HOLD_CYCLES(10), .EXPECTED(16'h55AA)) u_dut10 (
        .clk(clk), .rst(rst10), .start(start10), .a(a10), .b(b10), .c(c10), .d(d10),
        .q(q10), .busy(busy10), .done(done10), .table_out(tbl10), .mismatch(mm10)
    );

    p1_sweep_ctrl #(.HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3), .a(a3), .b(b3), .c(c3), .d(d3),
        .q(q3), .busy(busy3), .done(done3), .table_out(tbl3), .mismatch(mm3)
    );

    p1_sweep_ctrl #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .c(c1), .d(d1),
        .q(q1), .busy(busy1), .done(done1), .table_out(tbl1), .mismatch(mm1)
    );

    task automatic test_reset();
        rst10 = 1'b1; rst3 = 1'b1; rst1 = 1'b1;
        start10 = 1'b0; start3 = 1'b0; start1 = 1'b0;
        corrupt10 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a10, b10, c10, d10, busy10, done10, mm10} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outs10 got %b want 0000000", {a10, b10, c10, d10, busy10, done10, mm10});
        end
        checks++;
        if (tbl10 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_table10 got %h want 0000", tbl10);
        end
        checks++;
        if ({a3, b3, c3, d3, busy3, done3, mm3, tbl3} !== 23'b0) begin
            errors++;
            $display("FAIL reset_all3 got %h want 0", {a3, b3, c3, d3, busy3, done3, mm3, tbl3});
        end
        checks++;
        if ({a1, b1, c1, d1, busy1, done1, mm1, tbl1} !== 23'b0) begin
            errors++;
            $display("FAIL reset_all1 got %h want 0", {a1, b1, c1, d1, busy1, done1, mm1, tbl1});
        end
        rst10 = 1'b0; rst3 = 1'b0; rst1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy10, busy3, busy1, done10, done3, done1} !== 6'b0) begin
            errors++;
            $display("FAIL idle_no_start got %b want 000000", {busy10, busy3, busy1, done10, done3, done1});
        end
    endtask

    // One full a^d sweep on the hold-10 unit; expected table/mismatch queued at start.
    task automatic run_sweep10(input logic [15:0] exp_tbl, input logic exp_mm, input string name);
        int t;
        int busy_cnt;
        logic [15:0] et;
        logic em;
        exp_tbl10.push_back(exp_tbl);
        exp_mm10.push_back(exp_mm);
        @(negedge clk) start10 = 1'b1;
        @(negedge clk) start10 = 1'b0;
        checks++;
        if (mm10 !== 1'b0) begin
            errors++;
            $display("FAIL %s_mm_clear_on_start got %b want 0", name, mm10);
        end
        t = 1;
        busy_cnt = 0;
        while (!done10 && t <= 400) begin
            if (busy10) busy_cnt++;
            @(negedge clk);
            t++;
        end
        checks++;
        if (done10 !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout got done=%b want 1 within 400 cycles", name, done10);
            exp_tbl10.delete();
            exp_mm10.delete();
        end else begin
            et = exp_tbl10.pop_front();
            em = exp_mm10.pop_front();
            checks++;
            if (t != 161) begin
                errors++;
                $display("FAIL %s_done_cycle got %0d want 161", name, t);
            end
            checks++;
            if (busy_cnt != 160 || busy10 !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy got cnt=%0d busy_at_done=%b want 160/0", name, busy_cnt, busy10);
            end
            checks++;
            if (tbl10 !== et) begin
                errors++;
                $display("FAIL %s_table got %h want %h", name, tbl10, et);
            end
            checks++;
            if (mm10 !== em) begin
                errors++;
                $display("FAIL %s_mismatch got %b want %b", name, mm10, em);
            end
        end
        @(negedge clk);
        checks++;
        if (done10 !== 1'b0 || tbl10 !== exp_tbl || mm10 !== exp_mm) begin
            errors++;
            $display("FAIL %s_after_done got done=%b tbl=%h mm=%b want 0/%h/%b",
                     name, done10, tbl10, mm10, exp_tbl, exp_mm);
        end
    endtask

    task automatic test_xor_table();
        corrupt10 = 1'b0;
        run_sweep10(16'h55AA, 1'b0, "xor");
    endtask

    task automatic test_vector_order();
        logic [3:0] ev;
        logic [15:0] et;
        for (int i = 0; i < 48; i++) exp_vec3.push_back(4'(i / 3));
        exp_vec3.push_back(4'd0);
        exp_tbl3.push_back(16'h55AA);
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        for (int t = 1; t <= 49; t++) begin
            ev = exp_vec3.pop_front();
            checks++;
            if ({a3, b3, c3, d3} !== ev) begin
                errors++;
                $display("FAIL vec_order t=%0d got %b want %b", t, {a3, b3, c3, d3}, ev);
            end
            if (t == 49) begin
                et = exp_tbl3.pop_front();
                checks++;
                if (done3 !== 1'b1 || busy3 !== 1'b0 || tbl3 !== et) begin
                    errors++;
                    $display("FAIL vec_order_fin got done=%b busy=%b tbl=%h want 1/0/%h", done3, busy3, tbl3, et);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_midsweep_reset();
        int t;
        int dones;
        int first_done;
        logic [15:0] et;
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        t = 1;
        while ({a3, b3, c3, d3} != 4'd7 && t <= 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if ({a3, b3, c3, d3} !== 4'd7 || tbl3 !== 16'h002A) begin
            errors++;
            $display("FAIL midsweep_vec7 got vec=%b tbl=%h want 0111/002a", {a3, b3, c3, d3}, tbl3);
        end
        rst3 = 1'b1;
        @(negedge clk);
        checks++;
        if ({a3, b3, c3, d3, busy3, done3, mm3} !== 7'b0 || tbl3 !== 16'h0000) begin
            errors++;
            $display("FAIL midsweep_reset got outs=%b tbl=%h want 0000000/0000",
                     {a3, b3, c3, d3, busy3, done3, mm3}, tbl3);
        end
        rst3 = 1'b0;
        @(negedge clk);
        exp_tbl3.push_back(16'h55AA);
        start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        dones = 0;
        first_done = 0;
        for (int k = 1; k <= 80; k++) begin
            start3 = (k == 5 || k == 20 || k == 40) ? 1'b1 : 1'b0;
            if (done3) begin
                dones++;
                if (dones == 1) begin
                    first_done = k;
                    et = exp_tbl3.pop_front();
                    checks++;
                    if (tbl3 !== et) begin
                        errors++;
                        $display("FAIL retrigger_table got %h want %h", tbl3, et);
                    end
                end
            end
            @(negedge clk);
        end
        start3 = 1'b0;
        checks++;
        if (dones != 1 || first_done != 49) begin
            errors++;
            $display("FAIL retrigger_done got count=%0d first=%0d want 1/49", dones, first_done);
        end
        exp_tbl3.delete();
    endtask

    task automatic test_min_hold();
        int t;
        logic [15:0] et;
        exp_tbl1.push_back(16'hFFFF);
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        t = 1;
        while (!done1 && t <= 100) begin
            @(negedge clk);
            t++;
        end
        et = exp_tbl1.pop_front();
        checks++;
        if (done1 !== 1'b1 || t != 17) begin
            errors++;
            $display("FAIL min_hold_done got done=%b t=%0d want 1/17", done1, t);
        end
        checks++;
        if (tbl1 !== et) begin
            errors++;
            $display("FAIL min_hold_table got %h want %h", tbl1, et);
        end
    endtask

    task automatic test_checker();
        corrupt10 = 1'b1;
        run_sweep10(16'h55A2, EXP_MM_CORRUPT, "corrupt");
        corrupt10 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mm10 !== EXP_MM_CORRUPT || tbl10 !== 16'h55A2) begin
            errors++;
            $display("FAIL checker_hold got mm=%b tbl=%h want %b/55a2", mm10, tbl10, EXP_MM_CORRUPT);
        end
        run_sweep10(16'h55AA, 1'b0, "recheck");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_xor_table();
        test_vector_order();
        test_midsweep_reset();
        test_min_hold();
        test_checker();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
